// File: rtl/booth_mac_if.sv
// ============================================================================
// Module   : booth_mac_if
// Function : Operand-in / frame-result-out valid/ready bundle for booth_mac_acc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface booth_mac_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_a;
    logic [11:0]      in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/booth_mac_acc.sv
// ============================================================================
// Module   : booth_mac_acc (+ Wallace_12x12 multiplier core)
// Function : Two-stage pipelined 12x12 multiply feeding a framed accumulator;
//            SAT_EN selects saturating instead of wrapping accumulation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_mac_acc #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       clear,
    booth_mac_if.slave      bus
);
    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_FLUSH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [ACC_W-1:0] c_acc_max = '1;

    state_t           r_state;
    logic [11:0]      r_a, r_b;
    logic             r_v1, r_l1, r_v2, r_l2;
    logic [23:0]      r_prod;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_accept;
    logic [23:0]      w_prod;
    logic [ACC_W:0]   w_sum;

    Wallace_12x12 u_mul (
        .a (r_a),
        .b (r_b),
        .p (w_prod)
    );

    assign w_accept = bus.in_valid && (r_state == S_ACCUM);
    // Top bit of the widened sum is the accumulator carry-out.
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W-23){1'b0}}, r_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_a         <= '0;
            r_b         <= '0;
            r_v1        <= 1'b0;
            r_l1        <= 1'b0;
            r_v2        <= 1'b0;
            r_l2        <= 1'b0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= S_ACCUM;
            r_v1        <= 1'b0;
            r_l1        <= 1'b0;
            r_v2        <= 1'b0;
            r_l2        <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a  <= bus.in_a;
                r_b  <= bus.in_b;
                r_l1 <= bus.in_last;
            end
            r_v2   <= r_v1;
            r_l2   <= r_l1;
            r_prod <= w_prod;

            if (r_v2) begin
`ifdef SAT_EN
                r_acc <= w_sum[ACC_W] ? c_acc_max : w_sum[ACC_W-1:0];
`else
                r_acc <= w_sum[ACC_W-1:0];
`endif
                r_ovf <= r_ovf | w_sum[ACC_W];
                if (r_cnt != c_cnt_max)
                    r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_ACCUM: begin
                    if (w_accept && bus.in_last)
                        r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_v2 && r_l2) begin
                        r_state     <= S_HOLD;
                        r_out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Pipeline is empty here, so clearing cannot race an add.
                    if (bus.out_ready) begin
                        r_state     <= S_ACCUM;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = r_out_valid;
    assign bus.out_acc   = r_acc;
    assign bus.out_cnt   = r_cnt;
    assign bus.out_ovf   = r_ovf;
endmodule

// Radix-4 Booth recoding of the unsigned multiplier into seven partial
// products, reduced by a carry-save chain and one final carry-propagate add.
module Wallace_12x12 (
    input  wire logic [11:0] a,
    input  wire logic [11:0] b,
    output logic      [23:0] p
);
    logic [14:0] w_bx;
    logic [23:0] w_pp [7];
    logic [23:0] w_s, w_c, w_t;

    assign w_bx = {2'b00, b, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_pp
            logic [23:0] w_m1, w_m2, w_d;
            assign w_m1 = {12'b0, a};
            assign w_m2 = {11'b0, a, 1'b0};
            always_comb begin
                case (w_bx[2*gi+2 -: 3])
                    3'b001, 3'b010: w_d = w_m1;
                    3'b011:         w_d = w_m2;
                    3'b100:         w_d = -w_m2;
                    3'b101, 3'b110: w_d = -w_m1;
                    default:        w_d = '0;
                endcase
            end
            assign w_pp[gi] = w_d << (2*gi);
        end
    endgenerate

    always_comb begin
        w_s = '0;
        w_c = '0;
        w_t = '0;
        for (int i = 0; i < 7; i++) begin
            w_t = w_s ^ w_c ^ w_pp[i];
            w_c = ((w_s & w_c) | (w_s & w_pp[i]) | (w_c & w_pp[i])) << 1;
            w_s = w_t;
        end
    end

    assign p = w_s + w_c;
endmodule

`default_nettype wire

// File: tb/tb_booth_mac_acc.sv
// ============================================================================
// Module   : tb_booth_mac_acc
// Function : Directed self-checking bench for booth_mac_acc (ACC_W=26);
//            expectations track SAT_EN when it is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_booth_mac_acc;
    localparam int ACC_W = 26;
    localparam int CNT_W = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;

    int checks   = 0;
    int failures = 0;

    exp_t             sb[$];
    logic [ACC_W-1:0] m_acc;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovf;

    always #5 clk = ~clk;

    booth_mac_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    booth_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Drives one pair for one accepting edge and folds it into the model.
    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic last);
        logic [23:0]    p;
        logic [ACC_W:0] s;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        p = a * b;
        s = {1'b0, m_acc} + {{(ACC_W-23){1'b0}}, p};
        m_ovf = m_ovf | s[ACC_W];
`ifdef SAT_EN
        m_acc = s[ACC_W] ? '1 : s[ACC_W-1:0];
`else
        m_acc = s[ACC_W-1:0];
`endif
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (last) begin
            sb.push_back('{m_acc, m_cnt, m_ovf});
            model_reset();
        end
        tick();
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_acc"}, 64'(bus.out_acc), 64'(e.acc));
            check({tag, "_cnt"}, 64'(bus.out_cnt), 64'(e.cnt));
            check({tag, "_ovf"}, 64'(bus.out_ovf), 64'(e.ovf));
        end
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_rel_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_rel_acc"},   64'(bus.out_acc),  64'd0);
        check({tag, "_rel_cnt"},   64'(bus.out_cnt),  64'd0);
        check({tag, "_rel_ovf"},   64'(bus.out_ovf),  64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();

        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ready", 64'(bus.in_ready),  64'd1);
        check("rst_acc",   64'(bus.out_acc),   64'd0);
        check("rst_cnt",   64'(bus.out_cnt),   64'd0);
        check("rst_ovf",   64'(bus.out_ovf),   64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-frame: the partial sum is visible, then dropped asynchronously.
        send(12'd11, 12'd13, 1'b0);
        send(12'd17, 12'd19, 1'b0);
        idle();
        tick();
        check("mid_partial_cnt", 64'(bus.out_cnt), 64'd1);
        check("mid_partial_acc", 64'(bus.out_acc), 64'd143);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 64'(bus.in_ready),  64'd1);
        check("async_rst_acc",   64'(bus.out_acc),   64'd0);
        check("async_rst_cnt",   64'(bus.out_cnt),   64'd0);
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_cnt", 64'(bus.out_cnt), 64'd0);

        // Back-to-back three-term frame.
        send(12'd3, 12'd5, 1'b0);
        send(12'd7, 12'd9, 1'b0);
        send(12'd100, 12'd200, 1'b1);
        idle();
        check("frame3_flush_ready", 64'(bus.in_ready), 64'd0);
        wait_result("frame3", 2);
        check("frame3_acc_value", 64'(bus.out_acc), 64'd20078);
        check("frame3_cnt_value", 64'(bus.out_cnt), 64'd3);
        release_result("frame3");

        // Single-term frame at maximum operands.
        send(12'd4095, 12'd4095, 1'b1);
        idle();
        wait_result("single", 2);
        check("single_acc_value", 64'(bus.out_acc), 64'd16769025);
        check("single_cnt_value", 64'(bus.out_cnt), 64'd1);
        release_result("single");

        // Backpressure: result must hold for ten cycles without loss.
        send(12'd10, 12'd10, 1'b0);
        send(12'd20, 12'd20, 1'b1);
        idle();
        wait_result("bp", 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_acc",   64'(bus.out_acc),   64'd500);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_ready", 64'(bus.in_ready),  64'd0);
        end
        release_result("bp");
        send(12'd6, 12'd7, 1'b1);
        idle();
        wait_result("bp_next", 2);
        check("bp_next_acc_value", 64'(bus.out_acc), 64'd42);
        release_result("bp_next");

        // Accumulator carry-out over five maximal terms.
        for (int i = 0; i < 5; i++) send(12'd4095, 12'd4095, i == 4);
        idle();
        wait_result("ovf", 2);
`ifdef SAT_EN
        check("ovf_acc_value", 64'(bus.out_acc), 64'd67108863);
`else
        check("ovf_acc_value", 64'(bus.out_acc), 64'd16736261);
`endif
        check("ovf_flag_value", 64'(bus.out_ovf), 64'd1);
        release_result("ovf");

        // Clear after two terms; the pair offered with clear is discarded.
        send(12'd9, 12'd9, 1'b0);
        send(12'd8, 12'd8, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_a     = 12'd50;
        bus.in_b     = 12'd50;
        bus.in_last  = 1'b1;
        clear        = 1'b1;
        check("clear_ready", 64'(bus.in_ready), 64'd1);
        tick();
        clear = 1'b0;
        idle();
        model_reset();
        tick();
        tick();
        check("clear_acc",   64'(bus.out_acc),   64'd0);
        check("clear_cnt",   64'(bus.out_cnt),   64'd0);
        check("clear_valid", 64'(bus.out_valid), 64'd0);
        send(12'd2, 12'd2, 1'b1);
        idle();
        wait_result("after_clear", 2);
        check("after_clear_acc_value", 64'(bus.out_acc), 64'd4);
        check("after_clear_cnt_value", 64'(bus.out_cnt), 64'd1);
        release_result("after_clear");

        // Random operands.
        for (int i = 0; i < 6; i++)
            send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), i == 5);
        idle();
        wait_result("random", 2);
        release_result("random");

        // Term count saturates at all-ones.
        for (int i = 0; i < 300; i++) send(12'd1, 12'd1, i == 299);
        idle();
        wait_result("cnt_sat", 2);
        check("cnt_sat_value", 64'(bus.out_cnt), 64'd255);
        check("cnt_sat_acc",   64'(bus.out_acc), 64'd300);
        release_result("cnt_sat");

        // Clear while holding a result drops it.
        send(12'd5, 12'd5, 1'b1);
        idle();
        wait_result("hold_clear", 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("hold_clear_valid", 64'(bus.out_valid), 64'd0);
        check("hold_clear_ready", 64'(bus.in_ready),  64'd1);
        check("hold_clear_acc",   64'(bus.out_acc),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
